// File: rtl/pf_ccc_dri_master.sv
// Fabric-side initiator for the PolarFire CCC/PLL Dynamic Reconfiguration Interface.
// Turns single-word read/write commands into DRI transactions, with optional wait for PLL relock.
module pf_ccc_dri_master #(
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_SETTLE  = 16
) (
    input  logic        DRI_CLK,
    input  logic        DRI_ARST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic        cmd_relock,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic        irq_pending,
    input  logic        irq_clr,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    input  logic [32:0] DRI_RDATA,
    input  logic        DRI_INTERRUPT,
    input  logic        PLL_LOCK
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_LOCK,
        RESP
    } state_t;

    localparam logic [15:0] ACK_LIMIT  = 16'(ACK_TIMEOUT);
    localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT);
    localparam logic [15:0] SETTLE     = 16'(LOCK_SETTLE);

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic        relock_q;
    logic        lock_meta;
    logic        lock_s;
    logic [31:0] rdata_next;
    logic [1:0]  err_next;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        rdata_next = '0;
        err_next   = ERR_OK;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (DRI_RDATA[32]) begin
                    rdata_next = DRI_CTRL[9] ? 32'd0 : DRI_RDATA[31:0];
                    state_next = (DRI_CTRL[9] && relock_q) ? WAIT_LOCK : RESP;
                end else if (cnt == ACK_LIMIT) begin
                    err_next   = ERR_ACK;
                    state_next = RESP;
                end
            end
            WAIT_LOCK: begin
                if (lock_s && (cnt >= SETTLE)) begin
                    state_next = RESP;
                end else if (cnt == LOCK_LIMIT) begin
                    err_next   = ERR_LOCK;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            irq_pending <= 1'b0;
        end else if (DRI_INTERRUPT) begin
            irq_pending <= 1'b1;
        end else if (irq_clr) begin
            irq_pending <= 1'b0;
        end
    end

    // Outputs are registered from the next state so nothing reaches a port combinationally.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            relock_q  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            DRI_CTRL  <= '0;
            DRI_WDATA <= '0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);

            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            if ((state_next == RESP) && (state != RESP)) begin
                rsp_rdata <= rdata_next;
                rsp_err   <= err_next;
            end

            case (state_next)
                IDLE: begin
                    DRI_CTRL  <= '0;
                    DRI_WDATA <= '0;
                end
                ISSUE: begin
                    DRI_CTRL  <= {1'b1, cmd_write, 1'b0, cmd_addr};
                    DRI_WDATA <= cmd_write ? {1'b0, cmd_wdata} : 33'd0;
                    relock_q  <= cmd_relock;
                end
                default: begin
                    DRI_CTRL[10] <= 1'b0;
                end
            endcase
        end
    end

endmodule
